// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arbiter_pkg;

  typedef enum logic {
    ST_INIT,
    ST_SERVE
  } state_t;

  // Encoding of last_grant: which requester won most recently.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, favouring the port that did not win last.
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // NOTE: assign a default first so every path drives gnt and no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_grant == PORT_B)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one register-file RAM between requesters A and B; zero-fills it after reset,
// then grants one access per cycle round-robin and returns read data one cycle later.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_req,
  input  logic         a_we,
  input  logic [N-1:0] a_adr,
  input  logic [M-1:0] a_din,
  output logic         a_gnt,
  output logic         a_rvalid,
  output logic [M-1:0] a_rdata,
  input  logic         b_req,
  input  logic         b_we,
  input  logic [N-1:0] b_adr,
  input  logic [M-1:0] b_din,
  output logic         b_gnt,
  output logic         b_rvalid,
  output logic [M-1:0] b_rdata,
  output logic         busy,
  output logic         ram_we,
  output logic [N-1:0] ram_adr,
  output logic [M-1:0] ram_din,
  input  logic [M-1:0] ram_dout
);

  state_t       state;
  logic [N-1:0] fill_cnt;
  logic         last_grant;
  logic [1:0]   req;
  logic [1:0]   gnt;

  // Requests are masked during the fill so they simply wait.
  assign req   = {b_req, a_req} & {2{state == ST_SERVE}};
  assign busy  = (state == ST_INIT);
  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];

  rr_arb2 u_arb (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  always_comb begin
    ram_we  = 1'b0;
    ram_adr = '0;
    ram_din = '0;
    if (state == ST_INIT) begin
      ram_we  = 1'b1;
      ram_adr = fill_cnt;
    end else if (gnt[0]) begin
      ram_we  = a_we;
      ram_adr = a_adr;
      ram_din = a_din;
    end else if (gnt[1]) begin
      ram_we  = b_we;
      ram_adr = b_adr;
      ram_din = b_din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_INIT;
      fill_cnt   <= '0;
      last_grant <= PORT_B;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      case (state)
        ST_INIT: begin
          fill_cnt <= fill_cnt + N'(1);
          if (&fill_cnt) state <= ST_SERVE;
        end
        ST_SERVE: begin
          if (gnt[0]) begin
            last_grant <= PORT_A;
            if (!a_we) begin
              a_rvalid <= 1'b1;
              a_rdata  <= ram_dout;
            end
          end else if (gnt[1]) begin
            last_grant <= PORT_B;
            if (!b_we) begin
              b_rvalid <= 1'b1;
              b_rdata  <= ram_dout;
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
